// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - shared types and opcodes for the SPI target register block
package spi_target_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RDATA,
        IGNORE
    } state_t;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;

endpackage

// File: rtl/spi_target_sync.sv
// rtl/spi_target_sync.sv - 2-flop synchroniser with rise/fall detect on the synchronised sample
module spi_target_sync #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;
    logic [W-1:0] r_prev;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= async_i;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign sync_o = r_sync;
    assign rise_o = r_sync & ~r_prev;
    assign fall_o = ~r_sync & r_prev;

endmodule

// File: rtl/spi_target_regs.sv
// rtl/spi_target_regs.sv - SPI mode-0 target with byte register file and local port
// Optional feature macro: SPI_TARGET_AUTOINC_EN (address auto-increment per data byte).
module spi_target_regs
    import spi_target_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          sclk_i,
    input  logic          cs_i,
    input  logic          mosi_i,
    output logic          miso_o,
    output logic          miso_oe_o,
    input  logic          loc_we_i,
    input  logic [AW-1:0] loc_addr_i,
    input  logic [7:0]    loc_wdata_i,
    output logic [7:0]    loc_rdata_o,
    output logic          wr_valid_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [7:0]    wr_data_o,
    output logic          busy_o
);

`ifdef SPI_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic [7:0]    r_mem [DEPTH];
    state_t        r_state;
    logic [2:0]    r_bit_cnt;
    logic [6:0]    r_shift_in;
    logic [7:0]    r_shift_out;
    logic [AW-1:0] r_addr;
    logic          r_is_read;
    logic          r_miso;
    logic          r_miso_oe;
    logic          r_wr_valid;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;
    logic [1:0]    r_settle;
    logic          r_armed;

    logic [2:0]    w_sync;
    logic [2:0]    w_rise;
    logic [2:0]    w_fall;
    logic          w_cs;
    logic          w_mosi;
    logic          w_sclk_rise;
    logic          w_sclk_fall;
    logic          w_cs_rise;
    logic          w_cs_fall;
    logic [7:0]    w_byte;
    logic [AW-1:0] w_addr_next;
    logic          w_unused;

    spi_target_sync #(.W(3)) u_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i ({sclk_i, cs_i, mosi_i}),
        .sync_o  (w_sync),
        .rise_o  (w_rise),
        .fall_o  (w_fall)
    );

    assign w_cs        = w_sync[1];
    assign w_mosi      = w_sync[0];
    assign w_sclk_rise = w_rise[2];
    assign w_sclk_fall = w_fall[2];
    assign w_cs_rise   = w_rise[1];
    assign w_cs_fall   = w_fall[1];
    assign w_unused    = &{1'b0, w_sync[2], w_rise[0], w_fall[0]};

    assign w_byte      = {r_shift_in, w_mosi};
    assign w_addr_next = AUTOINC ? r_addr + AW'(1) : r_addr;

    // The synchroniser resets to 0, so a CS held high across reset looks like a rise;
    // only arm once a settled, genuinely low CS has been observed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_settle <= '0;
            r_armed  <= 1'b0;
        end else begin
            r_settle <= {r_settle[0], 1'b1};
            if (r_settle[1] && !w_cs) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift_in  <= '0;
            r_shift_out <= '0;
            r_addr      <= '0;
            r_is_read   <= 1'b0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_valid <= 1'b0;
            // Local write comes first so a same-address SPI write below overrides it.
            if (loc_we_i) begin
                r_mem[loc_addr_i] <= loc_wdata_i;
            end
            if (w_cs_fall) begin
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                r_miso    <= 1'b0;
                r_miso_oe <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_miso    <= 1'b0;
                        r_miso_oe <= 1'b0;
                        if (w_cs_rise && r_armed) begin
                            r_state   <= CMD;
                            r_bit_cnt <= '0;
                        end
                    end
                    CMD: begin
                        if (w_sclk_rise) begin
                            r_shift_in <= w_byte[6:0];
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_is_read <= (w_byte == OP_READ);
                                r_state   <= (w_byte == OP_WRITE || w_byte == OP_READ) ? ADDR : IGNORE;
                            end
                        end
                    end
                    ADDR: begin
                        if (w_sclk_rise) begin
                            r_shift_in <= w_byte[6:0];
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_addr  <= w_byte[AW-1:0];
                                r_state <= r_is_read ? RDATA : WDATA;
                            end
                        end
                    end
                    WDATA: begin
                        if (w_sclk_rise) begin
                            r_shift_in <= w_byte[6:0];
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_mem[r_addr] <= w_byte;
                                r_wr_valid    <= 1'b1;
                                r_wr_addr     <= r_addr;
                                r_wr_data     <= w_byte;
                                r_addr        <= w_addr_next;
                            end
                        end
                    end
                    RDATA: begin
                        if (w_sclk_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_addr <= w_addr_next;
                            end
                        end else if (w_sclk_fall) begin
                            r_miso_oe <= 1'b1;
                            // Bit count 0 marks a byte boundary: snapshot the register here.
                            if (r_bit_cnt == 3'd0) begin
                                r_miso      <= r_mem[r_addr][7];
                                r_shift_out <= {r_mem[r_addr][6:0], 1'b0};
                            end else begin
                                r_miso      <= r_shift_out[7];
                                r_shift_out <= {r_shift_out[6:0], 1'b0};
                            end
                        end
                    end
                    IGNORE: begin
                        r_miso_oe <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign miso_o      = r_miso;
    assign miso_oe_o   = r_miso_oe;
    assign wr_valid_o  = r_wr_valid;
    assign wr_addr_o   = r_wr_addr;
    assign wr_data_o   = r_wr_data;
    assign busy_o      = w_cs;
    assign loc_rdata_o = r_mem[loc_addr_i];

endmodule
